pipe_hazard_ctrl: RTL
=====================

Name: pipe_hazard_ctrl

Overview:
- Parametrised hazard and forwarding controller for the 5-stage pipelined datapath (F/D/E/M/W).
- Generalises the existing hazard unit in three ways:
  - N source operands per instruction instead of two fixed ones.
  - Configurable register-address width.
  - A multicycle execute unit (e.g. MUL) that holds E for MUL_LAT cycles, tracked by an internal FSM/counter.
- Drives the stall, flush and bubble controls of the pipeline registers and the per-operand forwarding-mux selects in E.

Parameters:
- NSRC, 2: source operands per instruction (≥1).
- AW, 4: register address width.
- PC_REG, 15: register index never forwarded (reads return PC+8 from D).
- MUL_LAT, 3: cycles a multicycle op occupies E (≥1).

Ports:
- clk  input  1  clock, all state on rising edge.
- reset  input  1  synchronous, active-low reset.
- src_addr_d  input  NSRC*AW  source register addresses in D; operand i at [i*AW +: AW].
- src_addr_e  input  NSRC*AW  source register addresses in E.
- rd_e, rd_m, rd_w  input  AW each  destination register in E/M/W.
- regwrite_e, regwrite_m, regwrite_w  input  1 each  register write enable per stage.
- memtoreg_e  input  1  instruction in E is a load.
- pcsrc_d, pcsrc_e, pcsrc_m, pcsrc_w  input  1 each  instruction in that stage writes PC.
- branch_taken_e  input  1  branch resolved taken in E.
- mul_start_e  input  1  instruction in E is a multicycle op.
- fwd_e  output  NSRC*2  forwarding select per operand: 00 regfile, 01 ResultW, 10 ALUResultM.
- stall_f, stall_d, stall_e  output  1 each  hold the F/D/E pipeline registers.
- flush_d, flush_e  output  1 each  clear the D/E pipeline registers.
- bubble_m  output  1  load a bubble into M.
- mul_busy  output  1  FSM in BUSY.
- mul_done  output  1  multicycle op completes this cycle.

Behaviour:
- Forwarding, per operand i (s = src_addr_e[i]), combinational:
  - 10 if regwrite_m && rd_m==s && s!=PC_REG.
  - else 01 if regwrite_w && rd_w==s && s!=PC_REG.
  - else 00.
  - M has priority over W.
- ldr_stall = memtoreg_e && regwrite_e && (any i: src_addr_d[i]==rd_e).
- pc_pend = pcsrc_d | pcsrc_e | pcsrc_m.
- Multicycle FSM, states IDLE and BUSY, counter width $clog2(MUL_LAT)+1:
  - IDLE, mul_start_e=1:
    - MUL_LAT==1: mul_hold=0, mul_done=1, stay IDLE.
    - Otherwise: mul_hold=1; go to BUSY with cnt=MUL_LAT-2.
  - BUSY, cnt>0: mul_hold=1, cnt decrements.
  - BUSY, cnt==0: mul_hold=0, mul_done=1, go to IDLE.
  - mul_start_e is ignored in BUSY (it is the same held instruction).
  - Net effect: stall_e is high for exactly MUL_LAT-1 cycles per op.
- Stall and flush outputs, combinational from inputs and state:
  - stall_f = ldr_stall | pc_pend | mul_hold.
  - stall_d = ldr_stall | mul_hold.
  - stall_e = mul_hold.
  - bubble_m = mul_hold.
  - flush_d = (pc_pend | pcsrc_w | branch_taken_e) & ~mul_hold.
  - flush_e = (ldr_stall | branch_taken_e) & ~mul_hold. A held E is never flushed.
- mul_busy = (state==BUSY).
- Reset (reset==0 at a clock edge):
  - Registered: state←IDLE, cnt←0.
  - While reset is low: stall_*=0, bubble_m=0, flush_d=flush_e=1, fwd_e=0, mul_busy=0, mul_done=0.
  - Reset asserted mid-BUSY aborts the op; the first cycle after release is IDLE.
- Simultaneous events:
  - ldr_stall and branch_taken_e together: flush_e=1, stall_d=1, flush_d=1. Flush wins in D.
  - rd_e matching PC_REG in a load: still causes ldr_stall (address compare only).

Optional Feature:
- Macro HAZARD_PERF_EN.
- When defined, adds three outputs, each 32-bit, wrapping, cleared by reset:
  - perf_stall_cnt: increments each cycle stall_d=1.
  - perf_flush_cnt: increments each cycle flush_e=1 (reset low excluded).
  - perf_mul_cnt: increments on each mul_done.
- When undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Forwarding priority: rd_m=rd_w=3, regwrite_m=regwrite_w=1, src_addr_e operand0=3, operand1=15 → fwd_e operand0=10, operand1=00. Then regwrite_m=0 → operand0=01.
- Load-use: memtoreg_e=1, regwrite_e=1, rd_e=5, src_addr_d operand1=5 → stall_f=stall_d=flush_e=1, flush_d=0, one cycle only.
- Multicycle, MUL_LAT=3: mul_start_e=1 held 3 cycles → stall_e/bubble_m high cycles 0–1, mul_busy high cycles 1–2, mul_done=1 in cycle 2, all low in cycle 3. With MUL_LAT=1 → no stall, mul_done=1 same cycle.
- Branch and PC write: branch_taken_e=1 → flush_d=flush_e=1. pcsrc_e=1 then pcsrc_m, then pcsrc_w on successive cycles → stall_f=1 for 2 cycles, flush_d=1 for 3.
- Reset mid-BUSY (MUL_LAT=4): drop reset in cycle 1 of op → flush_d=flush_e=1, stalls 0; after release mul_busy=0 and state is IDLE.
- HAZARD_PERF_EN: 2 load-use stalls and 1 MUL (MUL_LAT=3) → perf_stall_cnt=4, perf_flush_cnt=2, perf_mul_cnt=1.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and forwarding controller for the F/D/E/M/W pipeline: N-operand forwarding,
// load-use and PC-write stalls, and multicycle-execute hold. Optional perf counters: HAZARD_PERF_EN.
module pipe_hazard_ctrl #(
    parameter int unsigned NSRC    = 2,
    parameter int unsigned AW      = 4,
    parameter int unsigned PC_REG  = 15,
    parameter int unsigned MUL_LAT = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NSRC*AW-1:0]   src_addr_d,
    input  logic [NSRC*AW-1:0]   src_addr_e,
    input  logic [AW-1:0]        rd_e,
    input  logic [AW-1:0]        rd_m,
    input  logic [AW-1:0]        rd_w,
    input  logic                 regwrite_e,
    input  logic                 regwrite_m,
    input  logic                 regwrite_w,
    input  logic                 memtoreg_e,
    input  logic                 pcsrc_d,
    input  logic                 pcsrc_e,
    input  logic                 pcsrc_m,
    input  logic                 pcsrc_w,
    input  logic                 branch_taken_e,
    input  logic                 mul_start_e,
    output logic [NSRC*2-1:0]    fwd_e,
    output logic                 stall_f,
    output logic                 stall_d,
    output logic                 stall_e,
    output logic                 flush_d,
    output logic                 flush_e,
    output logic                 bubble_m,
    output logic                 mul_busy,
    output logic                 mul_done
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]          perf_stall_cnt,
    output logic [31:0]          perf_flush_cnt,
    output logic [31:0]          perf_mul_cnt
`endif
);

    localparam int unsigned CW = $clog2(MUL_LAT) + 1;
    localparam logic [CW-1:0] CNT_INIT = (MUL_LAT > 1) ? CW'(MUL_LAT - 2) : '0;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          hold_raw;
    logic          done_raw;
    logic          mul_hold;
    logic          ldr_stall;
    logic          pc_pend;
    logic [NSRC*2-1:0] fwd_raw;

    function automatic logic [1:0] fwd_sel(input logic [AW-1:0] s);
        if (regwrite_m && rd_m == s && s != AW'(PC_REG)) return 2'b10;
        if (regwrite_w && rd_w == s && s != AW'(PC_REG)) return 2'b01;
        return 2'b00;
    endfunction

    // Multicycle execute tracker; a start seen in BUSY is the same held op.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (mul_start_e && MUL_LAT != 1) begin
                        state <= BUSY;
                        cnt   <= CNT_INIT;
                    end
                end
                BUSY: begin
                    if (cnt != '0) cnt <= cnt - CW'(1);
                    else           state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        hold_raw = 1'b0;
        done_raw = 1'b0;
        case (state)
            IDLE: begin
                hold_raw = mul_start_e && (MUL_LAT != 1);
                done_raw = mul_start_e && (MUL_LAT == 1);
            end
            BUSY: begin
                hold_raw = (cnt != '0);
                done_raw = (cnt == '0);
            end
            default: ;
        endcase
    end

    always_comb begin
        fwd_raw   = '0;
        ldr_stall = 1'b0;
        for (int i = 0; i < int'(NSRC); i++) begin
            fwd_raw[i*2 +: 2] = fwd_sel(src_addr_e[i*AW +: AW]);
            if (src_addr_d[i*AW +: AW] == rd_e) ldr_stall = memtoreg_e && regwrite_e;
        end
    end

    assign pc_pend  = pcsrc_d | pcsrc_e | pcsrc_m;
    assign mul_hold = reset & hold_raw;

    // While reset is low the pipeline is held empty: flush both, stall nothing.
    assign fwd_e    = reset ? fwd_raw : '0;
    assign stall_f  = reset & (ldr_stall | pc_pend | mul_hold);
    assign stall_d  = reset & (ldr_stall | mul_hold);
    assign stall_e  = mul_hold;
    assign bubble_m = mul_hold;
    assign flush_d  = ~reset | ((pc_pend | pcsrc_w | branch_taken_e) & ~mul_hold);
    assign flush_e  = ~reset | ((ldr_stall | branch_taken_e) & ~mul_hold);
    assign mul_busy = reset & (state == BUSY);
    assign mul_done = reset & done_raw;

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            perf_stall_cnt <= '0;
            perf_flush_cnt <= '0;
            perf_mul_cnt   <= '0;
        end else begin
            perf_stall_cnt <= perf_stall_cnt + 32'(stall_d);
            perf_flush_cnt <= perf_flush_cnt + 32'(flush_e);
            perf_mul_cnt   <= perf_mul_cnt + 32'(mul_done);
        end
    end
`endif

endmodule
